// File: rtl/qsys_sdram_cpu_div_pkg.sv
// Shared types and constants for the qsys_sdram CPU divide cell.
//   div_state_t    : control FSM states (IDLE, CALC, FIX)
//   DIV_DATA_W     : CPU datapath width
//   DIV_CNT_W      : iteration counter width for the CPU datapath width
//   DIV_ZERO_QUOT  : quotient returned for a divide by zero
//   div_cnt_w()    : counter width for an arbitrary DATA_W
package qsys_sdram_cpu_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = $clog2(DIV_DATA_W);

    localparam logic [DIV_DATA_W-1:0] DIV_ZERO_QUOT = '1;

    function automatic int div_cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/qsys_sdram_cpu_div_step.sv
// One radix-2 restoring division iteration (purely combinational).
//   rem      : current partial remainder
//   q_msb    : next dividend bit, taken from the top of the quotient register
//   divisor  : divisor magnitude
//   rem_next : partial remainder after this iteration
//   q_bit    : quotient bit produced (1 = subtraction succeeded)
module qsys_sdram_cpu_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic              q_msb,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic              q_bit
);

    // The shifted remainder is kept DATA_W+1 bits wide: with divisors above
    // 2^(DATA_W-1) the partial remainder can have its MSB set, and dropping
    // it would corrupt the trial compare.
    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] sub;

    assign shifted = {rem, q_msb};
    assign q_bit   = (shifted >= {1'b0, divisor});
    // When the subtraction succeeds the result is below the divisor, so the
    // low DATA_W bits of the difference are the whole new remainder.
    assign sub      = shifted[DATA_W-1:0] - divisor;
    assign rem_next = q_bit ? sub : shifted[DATA_W-1:0];

endmodule

// File: rtl/qsys_sdram_cpu_div_cell.sv
// Iterative signed/unsigned integer divider for the CPU A-stage.
// Fixed latency of DATA_W+1 cycles from an accepted start to done, for every
// operand value and mode.
//   clk, reset         : clock, synchronous active-high reset
//   A_div_start        : request pulse, honoured only while idle
//   A_div_src1/src2    : dividend / divisor, sampled with start
//   A_div_signed       : 1 = two's-complement operands
//   A_div_rem_sel      : 1 = return remainder, 0 = return quotient
//   A_div_busy         : high from the cycle after an accepted start through FIX
//   A_div_done         : one-cycle pulse, result valid in that cycle
//   A_div_cell_result  : selected result, held until the next accepted start
//
// Handshake: a start is accepted on a rising edge where the cell is idle and
// A_div_start is high; starts while busy are dropped, not queued. done pulses
// once per accepted start (unless reset intervenes) in a cycle where busy is
// already low, so a new start may be presented in the done cycle.
module qsys_sdram_cpu_div_cell
    import qsys_sdram_cpu_div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              A_div_start,
    input  logic [DATA_W-1:0] A_div_src1,
    input  logic [DATA_W-1:0] A_div_src2,
    input  logic              A_div_signed,
    input  logic              A_div_rem_sel,
    output logic              A_div_busy,
    output logic              A_div_done,
    output logic [DATA_W-1:0] A_div_cell_result
);

    localparam int CNT_W = (DATA_W == DIV_DATA_W) ? DIV_CNT_W : div_cnt_w(DATA_W);
    localparam logic [DATA_W-1:0] ZERO_QUOT = DATA_W'(DIV_ZERO_QUOT);

    div_state_t        state;
    div_state_t        state_next;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] quot;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] divisor;
    logic              quot_neg;
    logic              rem_neg;
    logic              rem_sel;
    logic              div_zero;
    logic              done;
    logic [DATA_W-1:0] result;

    logic [DATA_W-1:0] rem_next;
    logic              q_bit;
    logic [DATA_W-1:0] quot_fixed;
    logic [DATA_W-1:0] rem_fixed;
    logic              src1_neg;
    logic              src2_neg;

    assign src1_neg = A_div_signed & A_div_src1[DATA_W-1];
    assign src2_neg = A_div_signed & A_div_src2[DATA_W-1];

    qsys_sdram_cpu_div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .rem      (rem),
        .q_msb    (quot[DATA_W-1]),
        .divisor  (divisor),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (A_div_start) state_next = CALC;
            CALC:    if (cnt == '0)   state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        A_div_busy = 1'b0;
        case (state)
            CALC, FIX: A_div_busy = 1'b1;
            default:   A_div_busy = 1'b0;
        endcase
    end

    // Sign fix-up. Negating the dividend magnitude restores the raw dividend,
    // so the divide-by-zero remainder needs no special case; only the
    // quotient is forced. INT_MIN / -1 wraps to INT_MIN by itself.
    assign quot_fixed = div_zero ? ZERO_QUOT : (quot_neg ? -quot : quot);
    assign rem_fixed  = rem_neg ? -rem : rem;

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            quot     <= '0;
            rem      <= '0;
            divisor  <= '0;
            quot_neg <= 1'b0;
            rem_neg  <= 1'b0;
            rem_sel  <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (A_div_start) begin
                        // The quotient register starts out holding the
                        // dividend magnitude; its bits shift out into the
                        // remainder as quotient bits shift in.
                        quot     <= src1_neg ? -A_div_src1 : A_div_src1;
                        divisor  <= src2_neg ? -A_div_src2 : A_div_src2;
                        quot_neg <= src1_neg ^ src2_neg;
                        rem_neg  <= src1_neg;
                        rem_sel  <= A_div_rem_sel;
                        div_zero <= (A_div_src2 == '0);
                        rem      <= '0;
                        cnt      <= CNT_W'(DATA_W - 1);
                    end
                end
                CALC: begin
                    rem  <= rem_next;
                    quot <= {quot[DATA_W-2:0], q_bit};
                    cnt  <= cnt - 1'b1;
                end
                FIX: begin
                    done   <= 1'b1;
                    result <= rem_sel ? rem_fixed : quot_fixed;
                end
                default: ;
            endcase
        end
    end

    assign A_div_done        = done;
    assign A_div_cell_result = result;

endmodule

// File: tb/tb_qsys_sdram_cpu_div_cell.sv
module tb_qsys_sdram_cpu_div_cell;

  localparam int W = 32;
  localparam int LAT = 33;

  typedef struct {
    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic         sg;
    logic         rs;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic         sgn = 1'b0;
  logic         rsel = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  logic [W-1:0] exp_q[$];
  int           start_q[$];
  string        name_q[$];
  vec_t         vecs[$];

  logic [W-1:0] mon_exp;
  int           mon_start;
  string        mon_name;

  qsys_sdram_cpu_div_cell #(.DATA_W(W)) dut (
    .clk               (clk),
    .reset             (reset),
    .A_div_start       (start),
    .A_div_src1        (src1),
    .A_div_src2        (src2),
    .A_div_signed      (sgn),
    .A_div_rem_sel     (rsel),
    .A_div_busy        (busy),
    .A_div_done        (done),
    .A_div_cell_result (result)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      check("busy_low_in_done", 32'(busy), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got result 0x%08h, expected no done", result);
      end else begin
        mon_exp   = exp_q.pop_front();
        mon_start = start_q.pop_front();
        mon_name  = name_q.pop_front();
        check(mon_name, result, mon_exp);
        check({mon_name, "_latency"}, 32'(edge_cnt - mon_start), 32'(LAT));
        check({mon_name, "_busy_cycles"}, 32'(busy_cnt), 32'(LAT));
      end
      busy_cnt = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] s1, input logic [W-1:0] s2, input logic sg,
                       input logic rs, input logic [W-1:0] exp, input string name, input bit sync);
    if (sync) @(negedge clk);
    start = 1'b1;
    src1  = s1;
    src2  = s2;
    sgn   = sg;
    rsel  = rs;
    exp_q.push_back(exp);
    start_q.push_back(edge_cnt + 1);
    name_q.push_back(name);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done within 60 cycles, expected done", name);
      exp_q.delete();
      start_q.delete();
      name_q.delete();
    end
  endtask

  task automatic add_vec(input logic [W-1:0] s1, input logic [W-1:0] s2, input logic sg,
                         input logic rs, input logic [W-1:0] exp, input string name);
    vec_t v;
    v.s1 = s1; v.s2 = s2; v.sg = sg; v.rs = rs; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [W-1:0] r1, r2, rexp;
    logic         rsg, rrs;
    logic signed [W-1:0] sa, sb;
    int d0;

    add_vec(32'd100,       32'd7,         1'b0, 1'b0, 32'd14,        "u_100_7_q");
    add_vec(32'd100,       32'd7,         1'b0, 1'b1, 32'd2,         "u_100_7_r");
    add_vec(-32'sd100,     32'd7,         1'b1, 1'b0, 32'hFFFFFFF2,  "s_m100_7_q");
    add_vec(-32'sd100,     32'd7,         1'b1, 1'b1, 32'hFFFFFFFE,  "s_m100_7_r");
    add_vec(32'd100,       -32'sd7,       1'b1, 1'b0, 32'hFFFFFFF2,  "s_100_m7_q");
    add_vec(32'd100,       -32'sd7,       1'b1, 1'b1, 32'd2,         "s_100_m7_r");
    add_vec(-32'sd7,       -32'sd2,       1'b1, 1'b0, 32'd3,         "s_m7_m2_q");
    add_vec(-32'sd7,       -32'sd2,       1'b1, 1'b1, 32'hFFFFFFFF,  "s_m7_m2_r");
    add_vec(32'h12345678,  32'd0,         1'b1, 1'b0, 32'hFFFFFFFF,  "s_dz_q");
    add_vec(32'h12345678,  32'd0,         1'b0, 1'b0, 32'hFFFFFFFF,  "u_dz_q");
    add_vec(32'h12345678,  32'd0,         1'b1, 1'b1, 32'h12345678,  "s_dz_r");
    add_vec(32'h12345678,  32'd0,         1'b0, 1'b1, 32'h12345678,  "u_dz_r");
    add_vec(32'h87654321,  32'd0,         1'b1, 1'b0, 32'hFFFFFFFF,  "s_dz_neg_q");
    add_vec(32'h87654321,  32'd0,         1'b1, 1'b1, 32'h87654321,  "s_dz_neg_r");
    add_vec(32'h80000000,  32'hFFFFFFFF,  1'b1, 1'b0, 32'h80000000,  "s_ovf_q");
    add_vec(32'h80000000,  32'hFFFFFFFF,  1'b1, 1'b1, 32'd0,         "s_ovf_r");
    add_vec(32'hFFFFFFFF,  32'd1,         1'b0, 1'b0, 32'hFFFFFFFF,  "u_max_1_q");
    add_vec(32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 1'b0, 32'd1,         "u_max_max_q");
    add_vec(32'hFFFFFFFE,  32'h80000001,  1'b0, 1'b1, 32'h7FFFFFFD,  "u_big_div_r");
    add_vec(32'h80000001,  32'hC0000000,  1'b0, 1'b1, 32'h80000001,  "u_small_big_r");

    // reset state
    repeat (3) @(negedge clk);
    check("reset_busy",   32'(busy), 32'd0);
    check("reset_done",   32'(done), 32'd0);
    check("reset_result", result,    32'd0);
    reset = 1'b0;

    // table-driven vectors
    foreach (vecs[i]) begin
      issue(vecs[i].s1, vecs[i].s2, vecs[i].sg, vecs[i].rs, vecs[i].exp, vecs[i].name, 1'b1);
      wait_done(vecs[i].name);
    end

    // start while busy is ignored
    issue(32'd100, 32'd7, 1'b0, 1'b0, 32'd14, "ignored_first", 1'b1);
    repeat (8) @(negedge clk);
    start = 1'b1; src1 = 32'd9; src2 = 32'd3; sgn = 1'b0; rsel = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored_first");
    repeat (3) @(negedge clk);
    check("ignored_hold_result", result,    32'd14);
    check("ignored_no_restart",  32'(busy), 32'd0);

    // start in the done cycle is accepted
    issue(32'd1000, 32'd10, 1'b0, 1'b0, 32'd100, "b2b_first", 1'b1);
    wait_done("b2b_first");
    issue(32'd1000, 32'd10, 1'b0, 1'b1, 32'd0, "b2b_second", 1'b0);
    wait_done("b2b_second");

    // reset in the middle of CALC aborts, coincident start dropped
    @(negedge clk);
    start = 1'b1; src1 = 32'h0000FFFF; src2 = 32'd3; sgn = 1'b0; rsel = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    start = 1'b1; src1 = 32'd50; src2 = 32'd5;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    busy_cnt = 0;
    check("abort_busy",   32'(busy), 32'd0);
    check("abort_done",   32'(done), 32'd0);
    check("abort_result", result,    32'd0);
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    check("abort_idle",    32'(busy),     32'd0);
    issue(32'd9, 32'd3, 1'b0, 1'b0, 32'd3, "after_abort", 1'b1);
    wait_done("after_abort");

    // random operands against a behavioural model
    for (int i = 0; i < 12; i++) begin
      r1  = $urandom;
      r2  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300));
      rsg = 1'($urandom_range(0, 1));
      rrs = 1'($urandom_range(0, 1));
      if (r2 == 32'd0) r2 = 32'd1;
      if (rsg && r1 == 32'h80000000 && r2 == 32'hFFFFFFFF) r2 = 32'd3;
      if (rsg) begin
        sa = r1;
        sb = r2;
        rexp = rrs ? (sa % sb) : (sa / sb);
      end else begin
        rexp = rrs ? (r1 % r2) : (r1 / r2);
      end
      issue(r1, r2, rsg, rrs, rexp, "rand", 1'b1);
      wait_done("rand");
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
